// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudokuRAM port-A arbiter.
// The board store holds 4 rows of 24-bit row words.
package sudoku_pkg;

  localparam int ROW_W  = 24;
  localparam int ADDR_W = 2;

  localparam logic REQ_UI = 1'b0;
  localparam logic REQ_BG = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sudoku_ram_arbiter.sv
// Two-requester arbiter for sudokuRAM port A: UI controller has priority, the
// background client is guaranteed a grant after MAX_WAIT consecutive UI wins.
module sudoku_ram_arbiter
  import sudoku_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ROW_W-1:0]  wdata0,
  input  logic [ROW_W-1:0]  wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ROW_W-1:0]  rdata,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [ROW_W-1:0]  RamWriteBuf,
  output logic              RamWriteBit,
  input  logic [ROW_W-1:0]  RamDat
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LOAD  = CW'(RD_LAT - 1);

  arb_state_t      state_reg, state_next;
  logic            owner_reg;
  logic            we_reg;
  logic [SW-1:0]   starve_reg;
  logic [CW-1:0]   wait_cnt_reg;

  logic bg_due;
  logic winner;

  // Background client overrides priority only once it has been passed over enough.
  assign bg_due = req1 && (starve_reg == STARVE_MAX);
  assign winner = (req0 && !bg_due) ? REQ_UI : REQ_BG;

  always_comb begin
    state_next  = state_reg;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    rvalid0     = 1'b0;
    rvalid1     = 1'b0;
    RamWriteBit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) state_next = GRANT;
      end
      GRANT: begin
        gnt0        = (owner_reg == REQ_UI);
        gnt1        = (owner_reg == REQ_BG);
        RamWriteBit = we_reg;
        state_next  = we_reg ? IDLE : WAIT;
      end
      WAIT: begin
        if (wait_cnt_reg == '0) state_next = RESP;
      end
      RESP: begin
        rvalid0    = (owner_reg == REQ_UI);
        rvalid1    = (owner_reg == REQ_BG);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      owner_reg    <= REQ_UI;
      we_reg       <= 1'b0;
      starve_reg   <= '0;
      wait_cnt_reg <= '0;
      RamAddr      <= '0;
      RamWriteBuf  <= '0;
      rdata        <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            owner_reg   <= winner;
            we_reg      <= (winner == REQ_BG) ? we1 : we0;
            RamAddr     <= (winner == REQ_BG) ? addr1 : addr0;
            RamWriteBuf <= (winner == REQ_BG) ? wdata1 : wdata0;
            if (winner == REQ_BG)
              starve_reg <= '0;
            else if (req1 && (starve_reg != STARVE_MAX))
              starve_reg <= starve_reg + 1'b1;
          end
        end
        GRANT: begin
          wait_cnt_reg <= WAIT_LOAD;
        end
        WAIT: begin
          // Last WAIT cycle: RamDat is valid for the address sampled at the end of GRANT.
          if (wait_cnt_reg == '0)
            rdata <= RamDat;
          else
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_ram_arbiter.sv
// Randomized scoreboard bench for sudoku_ram_arbiter with a latency-accurate RAM model
// and a transaction-level reference of the board contents and arbitration rule.
module tb_sudoku_ram_arbiter;
  import sudoku_pkg::*;

  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 3;

  typedef struct {
    int          id;
    logic [23:0] data;
    int          due;
  } exp_t;

  logic        CLK, RST;
  logic        req0, req1, we0, we1;
  logic [1:0]  addr0, addr1;
  logic [23:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, RamWriteBit;
  logic [23:0] rdata, RamWriteBuf, RamDat;
  logic [1:0]  RamAddr;

  int tests;
  int fails;
  int cyc;
  logic snap0, snap1;
  exp_t exp_q[$];
  int   gnt_log[$];
  int   wren_cycles;
  int   rv_count0;
  logic [23:0] last_rd0, last_rd1;

  sudoku_ram_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .RamAddr(RamAddr), .RamWriteBuf(RamWriteBuf),
    .RamWriteBit(RamWriteBit), .RamDat(RamDat)
  );

  function automatic logic [23:0] init_row(input int i);
    case (i)
      0:       return 24'h120000;
      1:       return 24'h004000;
      2:       return 24'h000300;
      default: return 24'h000021;
    endcase
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    snap0 = req0;
    snap1 = req1;
  end

  // RAM port A: synchronous write, read data valid RD_LAT cycles after the sampling edge.
  logic [23:0] ram_mem  [4];
  logic [23:0] ram_pipe [RD_LAT];
  assign RamDat = ram_pipe[RD_LAT-1];

  initial begin
    for (int i = 0; i < 4; i++) ram_mem[i] = init_row(i);
    for (int k = 0; k < RD_LAT; k++) ram_pipe[k] = '0;
    forever begin
      @(posedge CLK);
      for (int k = RD_LAT - 1; k > 0; k--) ram_pipe[k] <= ram_pipe[k-1];
      ram_pipe[0] <= ram_mem[RamAddr];
      if (RamWriteBit) ram_mem[RamAddr] <= RamWriteBuf;
    end
  end

  // Monitor: predicts each grant from the sampled requests, pushes read expectations, checks responses.
  initial begin
    logic [23:0] shadow [4];
    int          passed;
    int          w, exp_w;
    logic [1:0]  a;
    logic        wr;
    logic [23:0] d;
    logic [23:0] rd_hold;
    exp_t        e;
    for (int i = 0; i < 4; i++) shadow[i] = init_row(i);
    passed = 0;
    rd_hold = '0;
    wren_cycles = 0;
    rv_count0 = 0;
    last_rd0 = '0;
    last_rd1 = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        exp_q.delete();
        passed  = 0;
        rd_hold = '0;
        continue;
      end
      if (RamWriteBit) wren_cycles++;
      if (gnt0 || gnt1) begin
        tests++;
        if (gnt0 && gnt1) begin
          fails++;
          $display("FAIL gnt_onehot: gnt0=%0b gnt1=%0b, required exactly one", gnt0, gnt1);
        end else begin
          w = gnt1 ? 1 : 0;
          if (!snap0 && !snap1) exp_w = -1;
          else if (snap0 && !(snap1 && passed == MAX_WAIT)) exp_w = 0;
          else exp_w = 1;
          if (w != exp_w) begin
            fails++;
            $display("FAIL arb_winner: granted %0d, required %0d (cycle %0d)", w, exp_w, cyc);
          end
          gnt_log.push_back(w);
          if (w == 0 && snap1) passed = (passed < MAX_WAIT) ? passed + 1 : MAX_WAIT;
          else if (w == 1) passed = 0;
          a  = (w == 1) ? addr1 : addr0;
          wr = (w == 1) ? we1 : we0;
          d  = (w == 1) ? wdata1 : wdata0;
          tests++;
          if (RamAddr !== a || RamWriteBit !== wr || (wr && RamWriteBuf !== d)) begin
            fails++;
            $display("FAIL ram_drive: addr=%0d wren=%0b buf=%06h, required addr=%0d wren=%0b buf=%06h",
                     RamAddr, RamWriteBit, RamWriteBuf, a, wr, d);
          end
          if (wr) begin
            shadow[a] = d;
            tests++;
            if (rdata !== rd_hold) begin
              fails++;
              $display("FAIL rdata_hold: rdata=%06h during write, required %06h", rdata, rd_hold);
            end
          end else begin
            exp_q.push_back('{w, shadow[a], cyc + RD_LAT + 1});
          end
        end
      end else if (RamWriteBit) begin
        tests++;
        fails++;
        $display("FAIL wren_no_gnt: RamWriteBit=1 outside a grant cycle %0d", cyc);
      end
      if (rvalid0 || rvalid1) begin
        tests++;
        if (rvalid0) rv_count0++;
        if (exp_q.size() == 0 || (rvalid0 && rvalid1)) begin
          fails++;
          $display("FAIL rvalid_unexpected: rvalid0=%0b rvalid1=%0b, required no response", rvalid0, rvalid1);
        end else begin
          e = exp_q.pop_front();
          if ((rvalid1 ? 1 : 0) != e.id || rdata !== e.data || cyc != e.due) begin
            fails++;
            $display("FAIL read_resp: id=%0d data=%06h cycle=%0d, required id=%0d data=%06h cycle=%0d",
                     rvalid1 ? 1 : 0, rdata, cyc, e.id, e.data, e.due);
          end
          rd_hold = rdata;
          if (rvalid0) last_rd0 = rdata;
          else last_rd1 = rdata;
        end
      end
    end
  end

  task automatic check_zero(input string name);
    tests++;
    if ({gnt0, gnt1, rvalid0, rvalid1, RamWriteBit} !== 5'b0 || RamAddr !== 2'd0 ||
        RamWriteBuf !== 24'd0 || rdata !== 24'd0) begin
      fails++;
      $display("FAIL %s: gnt=%0b%0b rvalid=%0b%0b wren=%0b addr=%0d buf=%06h rdata=%06h, required all 0",
               name, gnt0, gnt1, rvalid0, rvalid1, RamWriteBit, RamAddr, RamWriteBuf, rdata);
    end
  endtask

  // Called on a falling edge; raises the request, holds it until the grant, then drops it.
  task automatic do_req(input int r, input logic wr, input logic [1:0] a, input logic [23:0] d,
                        input bit chk_lat);
    int c0;
    bit got;
    if (r == 0) begin we0 = wr; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin we1 = wr; addr1 = a; wdata1 = d; req1 = 1'b1; end
    c0  = cyc;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge CLK);
      if ((r == 0) ? gnt0 : gnt1) got = 1'b1;
    end
    if (r == 0) req0 = 1'b0;
    else req1 = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL gnt_timeout: requester %0d got no grant within 200 cycles", r);
    end else if (chk_lat && cyc != c0 + 1) begin
      fails++;
      $display("FAIL gnt_latency: requester %0d granted at cycle %0d, required %0d", r, cyc, c0 + 1);
    end
    $display("[TB] req%0d %s row %0d data %06h granted at cycle %0d", r, wr ? "write" : "read", a, d, cyc);
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d read responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_order(input string name, input int base, input int n, input logic [7:0] order);
    logic [7:0] ord;
    ord = order;
    for (int i = 0; i < n; i++) begin
      tests++;
      if (base + i >= gnt_log.size() || gnt_log[base+i] != int'(ord[n-1-i])) begin
        fails++;
        $display("FAIL %s: grant %0d went to %0d, required %0d", name, i,
                 (base + i < gnt_log.size()) ? gnt_log[base+i] : -1, ord[n-1-i]);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, w0, rv0;
    tests = 0;
    fails = 0;
    cyc = 0;
    RST = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    repeat (10) @(negedge CLK);
    check_zero("reset_state");
    RST = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      check_zero("idle_outputs");
    end

    do_req(0, 1'b0, 2'd1, 24'd0, 1'b1);
    wait_idle();
    tests++;
    if (last_rd0 !== 24'h004000) begin
      fails++;
      $display("FAIL read_row1: rdata=%06h, required 004000", last_rd0);
    end

    w0 = wren_cycles;
    do_req(1, 1'b1, 2'd2, 24'hABCDEF, 1'b1);
    wait_idle();
    tests++;
    if (wren_cycles - w0 != 1) begin
      fails++;
      $display("FAIL wren_width: RamWriteBit high %0d cycles, required 1", wren_cycles - w0);
    end
    do_req(1, 1'b0, 2'd2, 24'd0, 1'b1);
    wait_idle();
    tests++;
    if (last_rd1 !== 24'hABCDEF) begin
      fails++;
      $display("FAIL readback_row2: rdata=%06h, required abcdef", last_rd1);
    end

    base = gnt_log.size();
    fork
      for (int i = 0; i < 6; i++) do_req(0, 1'b0, 2'($urandom_range(0, 3)), 24'd0, 1'b0);
      for (int i = 0; i < 2; i++) do_req(1, 1'b0, 2'($urandom_range(0, 3)), 24'd0, 1'b0);
    join
    wait_idle();
    check_order("starve_order", base, 8, 8'b0001_0001);

    base = gnt_log.size();
    fork
      do_req(0, 1'b0, 2'd0, 24'd0, 1'b0);
      do_req(1, 1'b0, 2'd3, 24'd0, 1'b0);
    join
    wait_idle();
    check_order("simul_order", base, 2, 8'b0000_0001);

    rv0 = rv_count0;
    do_req(0, 1'b0, 2'd3, 24'd0, 1'b1);
    RST = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    tests++;
    if (rv_count0 != rv0) begin
      fails++;
      $display("FAIL reset_discard: %0d rvalid0 pulses after reset, required 0", rv_count0 - rv0);
    end
    do_req(0, 1'b0, 2'd1, 24'd0, 1'b1);
    wait_idle();
    tests++;
    if (rv_count0 != rv0 + 1 || last_rd0 !== 24'h004000) begin
      fails++;
      $display("FAIL read_after_reset: %0d responses data=%06h, required 1 with 004000",
               rv_count0 - rv0, last_rd0);
    end

    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        do_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom), 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        do_req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom), 1'b0);
      end
    join
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
